// File: rtl/sbus_mem.sv
// sbus_mem: behavioural SBUS internal memory sitting behind the MBOX SBUS port.
// Accepts quadword read/write starts, acknowledges them after ACK_DLY cycles,
// then streams requested words in interleave order (start word, then +1 mod 4).
// All outputs are registered; the next-cycle output values are computed together
// with the next state, so an output is high in exactly the cycle its state owns.
module sbus_mem #(
  parameter int AW      = 14,
  parameter int ACK_DLY = 2,
  parameter int RD_DLY  = 3
) (
  input  logic          clk,
  input  logic          CROBAR,
  input  logic          START,
  input  logic          RD_RQ,
  input  logic          WR_RQ,
  input  logic [3:0]    RQ,
  input  logic [AW-1:0] ADR,
  input  logic [35:0]   D_IN,
  output logic          ACKN,
  output logic          DATA_VALID,
  output logic [35:0]   D_OUT,
  output logic [1:0]    WORD_NUM,
  output logic          WR_TAKE,
  output logic          BUSY,
  output logic          ERR
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACKWAIT = 3'd1,
    RDWAIT  = 3'd2,
    RDXFER  = 3'd3,
    WRXFER  = 3'd4
  } state_t;

  // Counter load values. The ACKN cycle itself is the last ACKWAIT cycle, so the
  // read wait needs one cycle fewer than RD_DLY; RD_DLY=1 skips RDWAIT entirely.
  localparam logic [3:0] ACK_LOAD = 4'(ACK_DLY - 1);
  localparam logic [3:0] RD_LOAD  = (RD_DLY > 1) ? 4'(RD_DLY - 2) : 4'd0;

  logic [35:0] mem [2**AW];

  state_t        state, nxt_state;
  logic [3:0]    cnt, nxt_cnt;
  logic [3:0]    pend, nxt_pend;
  logic          is_rd, nxt_is_rd;
  logic [1:0]    first, nxt_first;
  logic [AW-3:0] base, nxt_base;
  logic          ack_n, dv_n, take_n, err_n;
  logic [1:0]    wn_n;
  logic [2:0]    pk;
  logic [3:0]    pend_clr;
  logic          idle;

  // First still-pending word when walking from 'from' upward with wrap; {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] from);
    logic [2:0] r;
    logic [1:0] w;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      w = from + 2'(k);
      if (mask[w]) r = {1'b1, w};
      else         r = r;
    end
    return r;
  endfunction

  assign pk       = pick(pend, first);
  assign pend_clr = pend & ~(4'b0001 << pk[1:0]);
  assign idle     = (state == IDLE);

  // Next-state, counter, transfer bookkeeping and next-cycle output values.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pend  = pend;
    nxt_is_rd = is_rd;
    nxt_first = first;
    nxt_base  = base;
    ack_n     = 1'b0;
    dv_n      = 1'b0;
    take_n    = 1'b0;
    wn_n      = 2'd0;
    // Sticky error: malformed start in IDLE, or any start while busy.
    err_n = ERR | (START & idle & ~(RD_RQ ^ WR_RQ)) | (START & ~idle);
    case (state)
      IDLE: begin
        if (START && (RD_RQ ^ WR_RQ)) begin
          nxt_state = ACKWAIT;
          nxt_cnt   = ACK_LOAD;
          ack_n     = (ACK_LOAD == 4'd0);
          nxt_is_rd = RD_RQ;
          nxt_pend  = RQ;
          nxt_first = ADR[1:0];
          nxt_base  = ADR[AW-1:2];
        end else begin
          nxt_state = IDLE;
        end
      end
      ACKWAIT: begin
        if (cnt != 4'd0) begin
          nxt_cnt = cnt - 4'd1;
          ack_n   = (cnt == 4'd1);
        end else if (pend == 4'd0) begin
          nxt_state = IDLE;
        end else if (!is_rd) begin
          nxt_state = WRXFER;
          take_n    = 1'b1;
          wn_n      = pk[1:0];
          nxt_pend  = pend_clr;
        end else if (RD_DLY == 1) begin
          nxt_state = RDXFER;
          dv_n      = 1'b1;
          wn_n      = pk[1:0];
          nxt_pend  = pend_clr;
        end else begin
          nxt_state = RDWAIT;
          nxt_cnt   = RD_LOAD;
        end
      end
      RDWAIT: begin
        if (cnt != 4'd0) begin
          nxt_cnt = cnt - 4'd1;
        end else begin
          nxt_state = RDXFER;
          dv_n      = 1'b1;
          wn_n      = pk[1:0];
          nxt_pend  = pend_clr;
        end
      end
      RDXFER: begin
        if (pk[2]) begin
          dv_n     = 1'b1;
          wn_n     = pk[1:0];
          nxt_pend = pend_clr;
        end else begin
          nxt_state = IDLE;
        end
      end
      WRXFER: begin
        if (pk[2]) begin
          take_n   = 1'b1;
          wn_n     = pk[1:0];
          nxt_pend = pend_clr;
        end else begin
          nxt_state = IDLE;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // State and registered outputs; CROBAR aborts any transfer and clears everything.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      pend       <= 4'd0;
      is_rd      <= 1'b0;
      first      <= 2'd0;
      base       <= '0;
      ACKN       <= 1'b0;
      DATA_VALID <= 1'b0;
      WR_TAKE    <= 1'b0;
      WORD_NUM   <= 2'd0;
      D_OUT      <= 36'd0;
      BUSY       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      pend       <= nxt_pend;
      is_rd      <= nxt_is_rd;
      first      <= nxt_first;
      base       <= nxt_base;
      ACKN       <= ack_n;
      DATA_VALID <= dv_n;
      WR_TAKE    <= take_n;
      WORD_NUM   <= wn_n;
      D_OUT      <= dv_n ? mem[{base, wn_n}] : 36'd0;
      BUSY       <= (nxt_state != IDLE);
      ERR        <= err_n;
    end
  end

  // Storage array: captures D_IN in every WR_TAKE cycle; contents survive CROBAR.
  always_ff @(posedge clk) begin
    if (WR_TAKE) mem[{base, WORD_NUM}] <= D_IN;
  end

endmodule

// File: tb/tb_sbus_mem.sv
// tb_sbus_mem: directed checks from the test plan plus randomized transactions
// compared against a behavioural memory model with timing derived from the
// ACK_DLY/RD_DLY rules.
module tb_sbus_mem;
  localparam int AW = 14, ACK_DLY = 2, RD_DLY = 3, NC = 16;

  logic clk = 1'b0;
  logic CROBAR, START, RD_RQ, WR_RQ;
  logic [3:0] RQ;
  logic [AW-1:0] ADR;
  logic [35:0] D_IN, D_OUT;
  logic ACKN, DATA_VALID, WR_TAKE, BUSY, ERR;
  logic [1:0] WORD_NUM;

  int checks = 0;
  int errors = 0;

  logic [35:0] model [int];

  logic        o_ack [NC+1];
  logic        o_dv  [NC+1];
  logic        o_take[NC+1];
  logic        o_busy[NC+1];
  logic        o_err [NC+1];
  logic [1:0]  o_wn  [NC+1];
  logic [35:0] o_dout[NC+1];

  sbus_mem #(.AW(AW), .ACK_DLY(ACK_DLY), .RD_DLY(RD_DLY)) dut (
    .clk(clk), .CROBAR(CROBAR), .START(START), .RD_RQ(RD_RQ), .WR_RQ(WR_RQ),
    .RQ(RQ), .ADR(ADR), .D_IN(D_IN), .ACKN(ACKN), .DATA_VALID(DATA_VALID),
    .D_OUT(D_OUT), .WORD_NUM(WORD_NUM), .WR_TAKE(WR_TAKE), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 clk = ~clk;

  // Interleave order of requested words starting at 'first'.
  task automatic word_order(input logic [3:0] rq, input logic [1:0] first,
                            output int n, output logic [3:0][1:0] ord);
    n = 0;
    ord = '0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] w;
      w = 2'((int'(first) + k) % 4);
      if (rq[w]) begin
        ord[n] = w;
        n++;
      end
    end
  endtask

  // Issue one START (cycle 0) and record outputs for cycles 1..NC. Acts as MBOX
  // by presenting write words in order after ACKN. Optional extra START / CROBAR.
  task automatic run_txn(input logic rd, input logic wr, input logic [3:0] rq,
                         input logic [AW-1:0] adr, input logic [3:0][35:0] wd,
                         input int xstart, input int xrst);
    int n, a;
    logic [3:0][1:0] ord;
    word_order(rq, adr[1:0], n, ord);
    @(negedge clk);
    START = 1'b1; RD_RQ = rd; WR_RQ = wr; RQ = rq; ADR = adr; D_IN = 36'd0;
    a = -1;
    for (int c = 1; c <= NC; c++) begin
      @(negedge clk);
      START  = (c == xstart);
      CROBAR = (c == xrst);
      o_ack[c] = ACKN; o_dv[c] = DATA_VALID; o_take[c] = WR_TAKE;
      o_busy[c] = BUSY; o_err[c] = ERR; o_wn[c] = WORD_NUM; o_dout[c] = D_OUT;
      if (ACKN && a < 0) a = c;
      if (a > 0 && c > a && (c - a - 1) < n) D_IN = wd[ord[c-a-1]];
      else D_IN = 36'd0;
    end
  endtask

  task automatic do_reset();
    CROBAR = 1'b1;
    @(negedge clk);
    @(negedge clk);
    CROBAR = 1'b0;
  endtask

  task automatic test_reset();
    START = 1'b0; RD_RQ = 1'b0; WR_RQ = 1'b0; RQ = 4'd0; ADR = '0; D_IN = 36'd0;
    do_reset();
    checks++;
    if ({ACKN, DATA_VALID, WR_TAKE, BUSY, ERR, WORD_NUM, D_OUT} !== 43'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0",
               {ACKN, DATA_VALID, WR_TAKE, BUSY, ERR, WORD_NUM, D_OUT});
    end
  endtask

  task automatic test_read_full();
    logic [1:0]  ew [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [35:0] ed [4] = '{36'h333, 36'h444, 36'h111, 36'h222};
    run_txn(1'b0, 1'b1, 4'hF, 14'h100, {36'h444, 36'h333, 36'h222, 36'h111}, 0, 0);
    run_txn(1'b1, 1'b0, 4'hF, 14'h102, '0, 0, 0);
    for (int c = 1; c <= NC; c++) begin
      checks++;
      if (o_ack[c] !== (c == 2)) begin
        errors++;
        $display("FAIL read_full_ackn cycle %0d got %b expected %b", c, o_ack[c], c == 2);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({o_dv[5+i], o_wn[5+i], o_dout[5+i]} !== {1'b1, ew[i], ed[i]}) begin
        errors++;
        $display("FAIL read_full_word cycle %0d got dv=%b wn=%0d d=%h expected dv=1 wn=%0d d=%h",
                 5 + i, o_dv[5+i], o_wn[5+i], o_dout[5+i], ew[i], ed[i]);
      end
    end
    checks++;
    if ({o_busy[8], o_busy[9], o_dv[9], o_dout[9]} !== {1'b1, 1'b0, 1'b0, 36'd0}) begin
      errors++;
      $display("FAIL read_full_end got busy8=%b busy9=%b dv9=%b d9=%h expected 1 0 0 0",
               o_busy[8], o_busy[9], o_dv[9], o_dout[9]);
    end
  endtask

  task automatic test_sparse_read();
    int ndv = 0;
    run_txn(1'b1, 1'b0, 4'b1010, 14'h100, '0, 0, 0);
    for (int c = 1; c <= NC; c++) if (o_dv[c] === 1'b1) ndv++;
    checks++;
    if ({o_ack[2], o_dv[5], o_wn[5], o_dout[5], o_dv[6], o_wn[6], o_dout[6]} !==
        {1'b1, 1'b1, 2'd1, 36'h222, 1'b1, 2'd3, 36'h444} || ndv != 2) begin
      errors++;
      $display("FAIL sparse_read got ack=%b wn=%0d,%0d d=%h,%h pulses=%0d expected ack=1 wn=1,3 d=222,444 pulses=2",
               o_ack[2], o_wn[5], o_wn[6], o_dout[5], o_dout[6], ndv);
    end
  endtask

  task automatic test_write();
    logic [1:0]  ew [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [35:0] ed [4] = '{36'hB, 36'hC, 36'hD, 36'hA};
    int ntk = 0;
    run_txn(1'b0, 1'b1, 4'hF, 14'h203, {36'hA, 36'hD, 36'hC, 36'hB}, 0, 0);
    for (int c = 1; c <= NC; c++) if (o_take[c] === 1'b1) ntk++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({o_take[3+i], o_wn[3+i]} !== {1'b1, ew[i]}) begin
        errors++;
        $display("FAIL write_take cycle %0d got take=%b wn=%0d expected take=1 wn=%0d",
                 3 + i, o_take[3+i], o_wn[3+i], ew[i]);
      end
    end
    checks++;
    if (ntk != 4 || o_busy[7] !== 1'b0) begin
      errors++;
      $display("FAIL write_end got takes=%0d busy7=%b expected 4 0", ntk, o_busy[7]);
    end
    run_txn(1'b1, 1'b0, 4'hF, 14'h200, '0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({o_dv[5+i], o_wn[5+i], o_dout[5+i]} !== {1'b1, 2'(i), ed[i]}) begin
        errors++;
        $display("FAIL write_readback word %0d got dv=%b wn=%0d d=%h expected dv=1 wn=%0d d=%h",
                 i, o_dv[5+i], o_wn[5+i], o_dout[5+i], i, ed[i]);
      end
    end
  endtask

  task automatic test_errors();
    int nack = 0;
    int nbusy = 0;
    run_txn(1'b1, 1'b1, 4'hF, 14'h100, '0, 0, 0);
    for (int c = 1; c <= NC; c++) begin
      if (o_ack[c] === 1'b1) nack++;
      if (o_busy[c] === 1'b1) nbusy++;
    end
    checks++;
    if (nack != 0 || nbusy != 0 || o_err[1] !== 1'b1) begin
      errors++;
      $display("FAIL err_both got acks=%0d busy=%0d err=%b expected 0 0 1", nack, nbusy, o_err[1]);
    end
    do_reset();
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("FAIL crobar_clears_err got %b expected 0", ERR);
    end
    // START while busy: ignored, read continues unchanged, ERR set.
    run_txn(1'b1, 1'b0, 4'hF, 14'h100, '0, 1, 0);
    nack = 0;
    for (int c = 1; c <= NC; c++) if (o_ack[c] === 1'b1) nack++;
    checks++;
    if (nack != 1 || o_err[NC] !== 1'b1 || o_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL busy_start got acks=%0d err1=%b errend=%b expected 1 0 1", nack, o_err[1], o_err[NC]);
    end
    checks++;
    if ({o_dout[5], o_dout[6], o_dout[7], o_dout[8], o_busy[9]} !==
        {36'h111, 36'h222, 36'h333, 36'h444, 1'b0}) begin
      errors++;
      $display("FAIL busy_start_data got %h %h %h %h busy9=%b expected 111 222 333 444 0",
               o_dout[5], o_dout[6], o_dout[7], o_dout[8], o_busy[9]);
    end
    do_reset();
  endtask

  task automatic test_empty_mask();
    int ndv = 0;
    run_txn(1'b1, 1'b0, 4'b0000, 14'h100, '0, 3, 0);
    for (int c = 1; c <= NC; c++) if (o_dv[c] === 1'b1) ndv++;
    checks++;
    if ({o_ack[2], o_busy[2], o_busy[3]} !== 3'b110 || ndv != 0) begin
      errors++;
      $display("FAIL empty_mask got ack2=%b busy2=%b busy3=%b dv=%0d expected 1 1 0 0",
               o_ack[2], o_busy[2], o_busy[3], ndv);
    end
    checks++;
    if ({o_busy[4], o_ack[5], o_busy[6], o_err[NC]} !== 4'b1100) begin
      errors++;
      $display("FAIL empty_then_start got busy4=%b ack5=%b busy6=%b err=%b expected 1 1 0 0",
               o_busy[4], o_ack[5], o_busy[6], o_err[NC]);
    end
  endtask

  task automatic test_reset_mid_read();
    int late = 0;
    run_txn(1'b1, 1'b0, 4'hF, 14'h100, '0, 0, 6);
    for (int c = 7; c <= NC; c++) if (o_dv[c] !== 1'b0 || o_busy[c] !== 1'b0) late++;
    checks++;
    if ({o_dv[6], o_dout[6]} !== {1'b1, 36'h222}) begin
      errors++;
      $display("FAIL mid_read_second got dv=%b d=%h expected 1 222", o_dv[6], o_dout[6]);
    end
    checks++;
    if ({o_ack[7], o_dv[7], o_take[7], o_busy[7], o_err[7], o_wn[7], o_dout[7]} !== 43'd0 || late != 0) begin
      errors++;
      $display("FAIL mid_read_abort got %h late=%0d expected 0 0",
               {o_ack[7], o_dv[7], o_take[7], o_busy[7], o_err[7], o_wn[7], o_dout[7]}, late);
    end
    run_txn(1'b1, 1'b0, 4'hF, 14'h100, '0, 0, 0);
    checks++;
    if ({o_dout[5], o_dout[6], o_dout[7], o_dout[8]} !== {36'h111, 36'h222, 36'h333, 36'h444}) begin
      errors++;
      $display("FAIL mid_read_retained got %h %h %h %h expected 111 222 333 444",
               o_dout[5], o_dout[6], o_dout[7], o_dout[8]);
    end
  endtask

  // Random traffic in region 0x1000..0x103F; first 16 transactions fill it.
  task automatic test_random();
    for (int t = 0; t < 56; t++) begin
      logic rd;
      logic [3:0] rq;
      logic [AW-1:0] adr;
      logic [3:0][35:0] wd;
      logic [3:0][1:0] ord;
      int n, endc;
      if (t < 16) begin
        rd = 1'b0; rq = 4'hF;
        adr = 14'h1000 + 14'(4 * t) + 14'($urandom_range(0, 3));
      end else begin
        rd = 1'($urandom_range(0, 1)); rq = 4'($urandom_range(0, 15));
        adr = 14'h1000 + 14'($urandom_range(0, 63));
      end
      for (int i = 0; i < 4; i++) wd[i] = {4'($urandom), 32'($urandom)};
      word_order(rq, adr[1:0], n, ord);
      run_txn(rd, ~rd, rq, adr, wd, 0, 0);
      if (n == 0) endc = ACK_DLY + 1;
      else if (rd) endc = ACK_DLY + RD_DLY + n;
      else endc = ACK_DLY + 1 + n;
      for (int c = 1; c <= NC; c++) begin
        int idx;
        logic inx, e_dv, e_take;
        logic [1:0] e_wn;
        logic [35:0] e_d;
        idx = rd ? c - (ACK_DLY + RD_DLY) : c - (ACK_DLY + 1);
        inx = (idx >= 0) && (idx < n);
        e_dv = rd && inx;
        e_take = !rd && inx;
        e_wn = inx ? ord[idx] : 2'd0;
        e_d = e_dv ? model[int'({adr[AW-1:2], e_wn})] : 36'd0;
        checks++;
        if ({o_ack[c], o_dv[c], o_take[c], o_busy[c], o_err[c], o_wn[c], o_dout[c]} !==
            {c == ACK_DLY, e_dv, e_take, c < endc, 1'b0, e_wn, e_d}) begin
          errors++;
          $display("FAIL random txn %0d cycle %0d got ack=%b dv=%b tk=%b busy=%b err=%b wn=%0d d=%h expected ack=%b dv=%b tk=%b busy=%b err=0 wn=%0d d=%h",
                   t, c, o_ack[c], o_dv[c], o_take[c], o_busy[c], o_err[c], o_wn[c], o_dout[c],
                   c == ACK_DLY, e_dv, e_take, c < endc, e_wn, e_d);
        end
      end
      if (!rd) for (int i = 0; i < n; i++) model[int'({adr[AW-1:2], ord[i]})] = wd[ord[i]];
    end
  endtask

  initial begin
    CROBAR = 1'b1;
    test_reset();
    test_read_full();
    test_sparse_read();
    test_write();
    test_errors();
    test_empty_mask();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
